// File: rtl/media_janela_rgb_pkg.sv
// ============================================================================
// Package     : pacote_visao
// Description : Shared vision constants: RGB565 field positions, default image
//               size, output widths and the window-average FSM state type.
//               MEDIA_JANELA_RGB888_EN widens the average outputs to 8 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pacote_visao;

  // RGB565 field positions (first camera byte is [15:8])
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Default frame geometry
  localparam int IMG_W_PADRAO = 320;
  localparam int IMG_H_PADRAO = 240;

  // Width of the average outputs
`ifdef MEDIA_JANELA_RGB888_EN
  localparam int LARG_R = 8;
  localparam int LARG_G = 8;
  localparam int LARG_B = 8;
`else
  localparam int LARG_R = 5;
  localparam int LARG_G = 6;
  localparam int LARG_B = 5;
`endif

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESPERA_QUADRO = 3'd1,
    ACUMULA       = 3'd2,
    CALCULA       = 3'd3,
    PRONTO        = 3'd4
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/media_janela_rgb_contador_xy.sv
// ============================================================================
// Module      : contador_xy
// Description : Pixel column/row counter. Column wraps at the end of a line and
//               bumps the row; the row saturates on the last line. Synchronous
//               zero has priority over advance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_xy #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int XW    = 9,
  parameter int YW    = 8
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          zerar,
  input  logic          avancar,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  // Column/row position of the next pixel to arrive
  always_ff @(posedge clock) begin
    if (clear || zerar) begin
      x <= '0;
      y <= '0;
    end else if (avancar) begin
      if (32'(x) == IMG_W - 1) begin
        x <= '0;
        if (32'(y) != IMG_H - 1) begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/media_janela_rgb.sv
// ============================================================================
// Module      : media_janela_rgb
// Description : Accumulates R/G/B of RGB565 pixels inside one power-of-two
//               window of a frame and reports the per-channel average.
//               Define MEDIA_JANELA_RGB888_EN for 8-bit expanded averages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module media_janela_rgb
  import pacote_visao::*;
#(
  parameter int IMG_W      = IMG_W_PADRAO,
  parameter int IMG_H      = IMG_H_PADRAO,
  parameter int WIN_X0     = 152,
  parameter int WIN_Y0     = 112,
  parameter int WIN_W_LOG2 = 4,
  parameter int WIN_H_LOG2 = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              iniciar,
  input  logic              vsync,
  input  logic              pixel_valido,
  input  logic [15:0]       pixel,
  output logic              ocupado,
  output logic              pronto,
  output logic [LARG_R-1:0] media_r,
  output logic [LARG_G-1:0] media_g,
  output logic [LARG_B-1:0] media_b
);

  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DESL  = WIN_W_LOG2 + WIN_H_LOG2;
  localparam int X_FIM = WIN_X0 + (1 << WIN_W_LOG2) - 1;
  localparam int Y_FIM = WIN_Y0 + (1 << WIN_H_LOG2) - 1;

  estado_t estado, proximo;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [5+DESL-1:0] soma_r;
  logic [6+DESL-1:0] soma_g;
  logic [5+DESL-1:0] soma_b;

  // vsync wins over a coincident pixel, so acceptance excludes it
  logic pixel_aceito;
  logic reinicia;
  logic na_janela;
  logic ultimo;

  assign pixel_aceito = (estado == ACUMULA) && pixel_valido && !vsync;
  assign reinicia     = vsync && ((estado == ESPERA_QUADRO) || (estado == ACUMULA));
  assign na_janela    = (32'(x) >= WIN_X0) && (32'(x) <= X_FIM) &&
                        (32'(y) >= WIN_Y0) && (32'(y) <= Y_FIM);
  assign ultimo       = pixel_aceito && (32'(x) == X_FIM) && (32'(y) == Y_FIM);

  contador_xy #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_contador_xy (
    .clock   (clock),
    .clear   (clear),
    .zerar   (reinicia),
    .avancar (pixel_aceito),
    .x       (x),
    .y       (y)
  );

  // State register
  always_ff @(posedge clock) begin
    if (clear) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Next-state logic
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:        if (iniciar) proximo = ESPERA_QUADRO;
      ESPERA_QUADRO: if (vsync)   proximo = ACUMULA;
      ACUMULA:       if (!vsync && ultimo) proximo = CALCULA;
      CALCULA:       proximo = PRONTO;
      PRONTO:        proximo = OCIOSO;
      default:       proximo = OCIOSO;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ocupado = (estado != OCIOSO);
    pronto  = (estado == PRONTO);
  end

  // Channel sums over the window; a frame start (or abort) clears them
  always_ff @(posedge clock) begin
    if (clear || reinicia) begin
      soma_r <= '0;
      soma_g <= '0;
      soma_b <= '0;
    end else if (pixel_aceito && na_janela) begin
      soma_r <= soma_r + (5+DESL)'(pixel[R_MSB:R_LSB]);
      soma_g <= soma_g + (6+DESL)'(pixel[G_MSB:G_LSB]);
      soma_b <= soma_b + (5+DESL)'(pixel[B_MSB:B_LSB]);
    end
  end

  // Averages are the top bits of each sum (truncating divide by window area)
  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  assign r5 = soma_r[DESL+4:DESL];
  assign g6 = soma_g[DESL+5:DESL];
  assign b5 = soma_b[DESL+4:DESL];

  // Register the averages once per run; they hold until the next result
  always_ff @(posedge clock) begin
    if (clear) begin
      media_r <= '0;
      media_g <= '0;
      media_b <= '0;
    end else if (estado == CALCULA) begin
`ifdef MEDIA_JANELA_RGB888_EN
      media_r <= {r5, r5[4:2]};
      media_g <= {g6, g6[5:4]};
      media_b <= {b5, b5[4:2]};
`else
      media_r <= r5;
      media_g <= g6;
      media_b <= b5;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_media_janela_rgb.sv
// ============================================================================
// Module      : tb_media_janela_rgb
// Description : Scoreboard bench for media_janela_rgb on a reduced 40x30 frame
//               with an 8x8 window at (19,14).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_media_janela_rgb;
  import pacote_visao::*;

  localparam int IW  = 40;
  localparam int IH  = 30;
  localparam int WX0 = 19;
  localparam int WY0 = 14;
  localparam int XF  = WX0 + 7;
  localparam int YF  = WY0 + 7;
  localparam int NPX = IW * IH;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              iniciar = 1'b0;
  logic              vsync = 1'b0;
  logic              pixel_valido = 1'b0;
  logic [15:0]       pixel = 16'h0000;
  logic              ocupado;
  logic              pronto;
  logic [LARG_R-1:0] media_r;
  logic [LARG_G-1:0] media_g;
  logic [LARG_B-1:0] media_b;

  typedef struct {
    int r;
    int g;
    int b;
    int cyc;
  } esperado_t;

  esperado_t fila[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic pronto_prev = 1'b0;

  media_janela_rgb #(
    .IMG_W      (IW),
    .IMG_H      (IH),
    .WIN_X0     (WX0),
    .WIN_Y0     (WY0),
    .WIN_W_LOG2 (3),
    .WIN_H_LOG2 (3)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .iniciar      (iniciar),
    .vsync        (vsync),
    .pixel_valido (pixel_valido),
    .pixel        (pixel),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .media_r      (media_r),
    .media_g      (media_g),
    .media_b      (media_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Stimulus patterns: 0 red, 1 green window on white, 2 alternating 1/0 blue
  // window on white, 3 full blue, 4 white
  function automatic logic [15:0] pix(input int mode, input int x, input int y);
    bit w;
    w = (x >= WX0) && (x <= XF) && (y >= WY0) && (y <= YF);
    case (mode)
      0:       return 16'hF800;
      1:       return w ? 16'h07E0 : 16'hFFFF;
      2:       return w ? ((x % 2 == 0) ? 16'h0001 : 16'h0000) : 16'hFFFF;
      3:       return 16'h001F;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Hand-computed averages per pattern
  function automatic esperado_t esperado(input int mode, input int c);
    esperado_t e;
    e.r = 0; e.g = 0; e.b = 0; e.cyc = c;
`ifdef MEDIA_JANELA_RGB888_EN
    case (mode)
      0: e.r = 255;
      1: e.g = 255;
      3: e.b = 255;
      default: ;
    endcase
`else
    case (mode)
      0: e.r = 31;
      1: e.g = 63;
      3: e.b = 31;
      default: ;
    endcase
`endif
    return e;
  endfunction

  // Monitor: compare every pronto against the head of the scoreboard
  always @(negedge clock) begin
    esperado_t e;
    if (pronto) begin
      if (fila.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pronto: got pronto=1 at cycle %0d, required no pronto", cyc);
      end else begin
        e = fila.pop_front();
        check("media_r", int'(media_r), e.r);
        check("media_g", int'(media_g), e.g);
        check("media_b", int'(media_b), e.b);
        check("latency_cycle", cyc, e.cyc);
        check("pronto_single", int'(pronto_prev), 0);
      end
    end
    pronto_prev <= pronto;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      iniciar = 1'b0; vsync = 1'b0; pixel_valido = 1'b0;
    end
  endtask

  task automatic start_run();
    @(negedge clock);
    iniciar = 1'b1; vsync = 1'b0; pixel_valido = 1'b0;
  endtask

  task automatic vsync_pulse(input bit with_valid);
    @(negedge clock);
    iniciar = 1'b0; vsync = 1'b1; pixel_valido = with_valid; pixel = 16'hFFFF;
  endtask

  // Stream npix pixels from (0,0); push the expectation at the last window pixel
  task automatic feed(input int mode, input int npix, input bit push, input int ini_at);
    for (int i = 0; i < npix; i++) begin
      int x;
      int y;
      x = i % IW;
      y = i / IW;
      @(negedge clock);
      vsync = 1'b0;
      iniciar = (i == ini_at);
      pixel_valido = 1'b1;
      pixel = pix(mode, x, y);
      if (push && x == XF && y == YF) fila.push_back(esperado(mode, cyc + 2));
    end
    @(negedge clock);
    pixel_valido = 1'b0; iniciar = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_ocupado", int'(ocupado), 0);
    check("reset_pronto", int'(pronto), 0);
    check("reset_media_r", int'(media_r), 0);
    check("reset_media_g", int'(media_g), 0);
    check("reset_media_b", int'(media_b), 0);
    clear = 1'b0;

    // Solid red, with a repeated iniciar while busy
    start_run();
    idle(1);
    check("ocupado_after_start", int'(ocupado), 1);
    start_run();
    vsync_pulse(1'b0);
    feed(0, NPX, 1'b1, -1);
    idle(3);
    check("idle_after_run", int'(ocupado), 0);

    // Window bounds, iniciar pulsed during accumulation
    start_run(); vsync_pulse(1'b0);
    feed(1, NPX, 1'b1, 5 * IW);
    idle(3);

    // Truncating average, then full blue
    start_run(); vsync_pulse(1'b0);
    feed(2, NPX, 1'b1, -1);
    idle(3);
    start_run(); vsync_pulse(1'b0);
    feed(3, NPX, 1'b1, -1);
    idle(3);

    // Frame abort mid-window, then a clean blue frame
    start_run(); vsync_pulse(1'b0);
    feed(4, (WY0 + 3) * IW + WX0 + 4, 1'b0, -1);
    vsync_pulse(1'b0);
    feed(3, NPX, 1'b1, -1);
    idle(3);

    // vsync coincident with a valid pixel: the pixel must be dropped
    start_run(); vsync_pulse(1'b0);
    feed(4, 3 * IW + 7, 1'b0, -1);
    vsync_pulse(1'b1);
    feed(1, NPX, 1'b1, -1);
    idle(3);

    // clear during accumulation: all outputs to zero, no result afterwards
    start_run(); vsync_pulse(1'b0);
    feed(4, (WY0 + 2) * IW + WX0 + 3, 1'b0, -1);
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    check("clear_ocupado", int'(ocupado), 0);
    check("clear_media_r", int'(media_r), 0);
    check("clear_media_g", int'(media_g), 0);
    check("clear_media_b", int'(media_b), 0);
    feed(3, NPX, 1'b0, -1);
    idle(5);

    check("all_results_seen", fila.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/media_janela_rgb.md
# media_janela_rgb

Downstream consumer of the 16-bit RGB565 pixel word assembled from camera byte pairs. Tracks pixel column/row within a frame, accumulates R, G and B over one rectangular sticker window, and outputs the per-channel average. Used by the cube-state reader to classify one facelet colour per run.

## Interface

**Parameters**
- `IMG_W`, default 320: pixels per line.
- `IMG_H`, default 240: lines per frame.
- `WIN_X0`, default 152: window first column.
- `WIN_Y0`, default 112: window first row.
- `WIN_W_LOG2`, default 4: window width is 2^WIN_W_LOG2.
- `WIN_H_LOG2`, default 4: window height is 2^WIN_H_LOG2.

**Ports**
- `clock` in 1: single clock, rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `iniciar` in 1: start request; one-cycle pulse.
- `vsync` in 1: frame start, one-cycle pulse, already synchronised to `clock`.
- `pixel_valido` in 1: `pixel` holds a complete new pixel this cycle.
- `pixel` in 16: RGB565 with R=[15:11], G=[10:5], B=[4:0]; the first camera byte is [15:8].
- `ocupado` out 1: high in every state except OCIOSO.
- `pronto` out 1: one-cycle result strobe.
- `media_r` out 5 (8 with macro): average red.
- `media_g` out 6 (8 with macro): average green.
- `media_b` out 5 (8 with macro): average blue.

## Operation

- **Reset values:** `clear` forces state OCIOSO. All outputs, counters and sums go to 0.
- **OCIOSO:**
  - `iniciar` moves to ESPERA_QUADRO.
  - Pixels are ignored.
- **ESPERA_QUADRO:**
  - `vsync` zeroes x, y and all sums, then moves to ACUMULA.
  - `pixel_valido` is ignored here.
- **ACUMULA:** on each `pixel_valido`, if WIN_X0 ≤ x < WIN_X0+2^WIN_W_LOG2 and WIN_Y0 ≤ y < WIN_Y0+2^WIN_H_LOG2, add the channel fields to `soma_r`/`soma_g`/`soma_b`. Then advance the counters:
  - x wraps from IMG_W-1 to 0 and y increments.
  - y saturates at IMG_H-1.
  - The last window pixel is the accepted pixel at the window's last column and last row. It moves the state to CALCULA.
- **CALCULA:**
  - Each average is the sum right-shifted by WIN_W_LOG2+WIN_H_LOG2 (truncating).
  - The averages are registered to the outputs.
  - The state moves to PRONTO.
- **PRONTO:** `pronto`=1 for this cycle only, then return to OCIOSO.
- **Sum widths:**
  - R and B: 5+WIN_W_LOG2+WIN_H_LOG2 bits.
  - G: 6+WIN_W_LOG2+WIN_H_LOG2 bits.
  - Overflow is impossible by construction.
- **Boundary conditions:**
  - `iniciar` while `ocupado`: ignored.
  - `vsync` during ACUMULA: frame aborted. Sums and counters are zeroed and accumulation restarts in ACUMULA.
  - `vsync` and `pixel_valido` in the same cycle: `vsync` wins and the pixel is dropped.
  - `clear` mid-run: back to reset values in the next cycle. There is no partial result.
  - Averages hold their value until the next CALCULA or `clear`.

## Timing

- Edge N accepts the last window pixel; CALCULA is active from N to N+1.
- Averages are valid and `pronto`=1 in the cycle after edge N+1.
- `pronto` drops after edge N+2. Averages hold.
- `iniciar` to ESPERA_QUADRO takes 1 cycle. `vsync` to ACUMULA takes 1 cycle.
- The block accepts one pixel per cycle, with no back-pressure.

## Configuration

- `MEDIA_JANELA_RGB888_EN` defined: `media_r`/`media_g`/`media_b` are 8 bits.
  - R and B expand as {v[4:0], v[4:2]}.
  - G expands as {v[5:0], v[5:4]}.
  - Expansion is registered in CALCULA with the same latency.
- Not defined: native 5/6/5-bit outputs with no expansion.

## Structure

- Shared package `pacote_visao` holds:
  - RGB565 field position constants;
  - the FSM state typedef (OCIOSO, ESPERA_QUADRO, ACUMULA, CALCULA, PRONTO);
  - the default image size constants.
- Sub-module `contador_xy`: the column/row counter with wrap, saturation and synchronous zero. It is instantiated once.

## Test plan

- **Solid colour:** reset, `iniciar`, `vsync`, then a full 320x240 frame of 16'hF800. Require `pronto` pulse; `media_r`=31, `media_g`=0, `media_b`=0 (RGB888 build: 255, 0, 0).
- **Window bounds:** window pixels = 16'h07E0, all other pixels = 16'hFFFF. Require `media_g`=63, `media_r`=0, `media_b`=0. A single off-by-one edge pixel must break this result.
- **Truncating average:** window alternates 16'h0001 and 16'h0000. Require `media_b`=0, since sum 128 >> 8 = 0. All 16'h001F gives `media_b`=31.
- **Frame abort:** `vsync` mid-window, then a clean frame of 16'h001F. Require a single `pronto` with `media_b`=31.
- **Control races:**
  - `iniciar` repeated while `ocupado` is ignored.
  - `vsync` with `pixel_valido` drops that pixel.
  - `clear` in ACUMULA returns all outputs to 0 and no `pronto` follows.
- **Latency:** the last window pixel accepted at cycle N gives `pronto` high exactly at cycle N+2, for one cycle.
